// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch queue memory, redirect and decode handshake bundle
interface inst_fetch_queue_if #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // instruction memory request/response
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    // control flow
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 halt;

    // decode side
    logic                 inst_valid;
    logic [WORD_SIZE-1:0] inst_data;
    logic [WORD_SIZE-1:0] inst_pc;
    logic                 inst_ready;

    // status
    logic [CW-1:0]        count;
    logic [WORD_SIZE-1:0] num_fetched;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, count, num_fetched,
        input  mem_ack, mem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, count, num_fetched,
        output mem_ack, mem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch engine with in-order instruction queue and redirect flush
module inst_fetch_queue #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    inst_fetch_queue_if.master bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // REQ: request on the bus whose data will be queued.
    // DROP: request still on the bus but a redirect has made its data stale.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] num_fetched_q, num_fetched_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        count_post;

    logic [WORD_SIZE-1:0] pc_mem   [DEPTH];
    logic [WORD_SIZE-1:0] inst_mem [DEPTH];

    logic pop;
    logic enq;

    // A redirect cancels both the decode pop and the enqueue of any acked word.
    assign pop = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;
    assign enq = (state_q == REQ) && bus.mem_ack && !bus.redirect_valid;

    // Occupancy after this edge's enqueue/dequeue; decides back-to-back issue.
    always_comb begin
        count_post = count_q;
        if (enq && !pop) begin
            count_post = count_q + 1'b1;
        end else if (!enq && pop) begin
            count_post = count_q - 1'b1;
        end
    end

    // Fetch FSM next state, request address, queue pointers and flush handling.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_post;
        head_d        = pop ? head_q + 1'b1 : head_q;
        tail_d        = enq ? tail_q + 1'b1 : tail_q;
        num_fetched_d = pop ? num_fetched_q + 1'b1 : num_fetched_q;

        if (bus.redirect_valid) begin
            count_d    = '0;
            head_d     = tail_q;
            fetch_pc_d = bus.redirect_pc;
        end

        case (state_q)
            IDLE: begin
                if (!bus.halt && !bus.redirect_valid && (count_q < FULL)) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    state_d = bus.mem_ack ? IDLE : DROP;
                end else if (bus.mem_ack) begin
                    fetch_pc_d = mem_addr_q + 1'b1;
                    if (!bus.halt && (count_post < FULL)) begin
                        mem_addr_d = mem_addr_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                // the stale word is consumed here; the new fetch starts from IDLE
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d != IDLE);
    end

    // State and control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            num_fetched_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fetch_pc_q    <= fetch_pc_d;
            num_fetched_q <= num_fetched_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: each accepted ack writes {pc, inst} at the tail.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]   <= mem_addr_q;
            inst_mem[tail_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.inst_valid  = (count_q != '0);
    assign bus.inst_data   = inst_mem[head_q];
    assign bus.inst_pc     = pc_mem[head_q];
    assign bus.count       = count_q;
    assign bus.num_fetched = num_fetched_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with random memory latency and redirects
module tb_inst_fetch_queue;
    localparam int           W        = 16;
    localparam int           DEPTH    = 4;
    localparam logic [W-1:0] RESET_PC = 16'h0000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    inst_fetch_queue_if #(.WORD_SIZE(W), .DEPTH(DEPTH)) bus ();

    inst_fetch_queue #(.WORD_SIZE(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: expected queue contents {pc, inst}, next fetch address, pops seen
    logic [31:0]  exp_q[$];
    logic [W-1:0] exp_pc;
    int           nf_model;

    // memory model: one tracked request
    bit           out_active;
    bit           out_drop;
    logic [W-1:0] out_addr;
    int           lat_left;
    bit           exp_req;
    bit           new_req;

    // stimulus knobs
    int           lat_lo, lat_hi, p_ready, p_redir;
    bit           halt_v;
    bit           force_redir;
    logic [W-1:0] force_pc;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_PC));
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_num_fetched", 32'(bus.num_fetched), 32'd0);
        exp_q.delete();
        exp_pc     = RESET_PC;
        nf_model   = 0;
        out_active = 1'b0;
        out_drop   = 1'b0;
        exp_req    = 1'b0;
        new_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock: choose inputs, predict from the rules, advance, compare.
    task automatic step();
        bit           ack, redir, ready, pop, acc, will_issue;
        logic [W-1:0] rpc;
        int           pre_cnt;

        ack = out_active && (lat_left == 0);
        if (out_active && lat_left != 0) lat_left--;
        if (!out_active && $urandom_range(7, 0) == 0) ack = 1'b1;
        redir       = force_redir || (int'($urandom_range(99, 0)) < p_redir);
        rpc         = force_redir ? force_pc : W'($urandom);
        force_redir = 1'b0;
        ready       = int'($urandom_range(99, 0)) < p_ready;

        bus.mem_ack        = ack;
        bus.mem_rdata      = out_active ? mem_word(out_addr) : W'($urandom);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.halt           = halt_v;
        bus.inst_ready     = ready;

        pre_cnt    = exp_q.size();
        pop        = (pre_cnt != 0) && ready && !redir;
        acc        = out_active && ack && !out_drop && !redir;
        will_issue = !halt_v && !redir &&
                     ((!out_active && pre_cnt < DEPTH) ||
                      (acc && (pre_cnt + 1 - int'(pop)) < DEPTH));
        if (redir) begin
            if (out_active) out_drop = 1'b1;
            exp_q.delete();
            exp_pc = rpc;
        end
        if (acc) begin
            exp_q.push_back({out_addr, mem_word(out_addr)});
            exp_pc = out_addr + 1'b1;
        end
        if (out_active && ack) out_active = 1'b0;
        exp_req = out_active || will_issue;

        @(posedge clk);
        #1;
        chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
        new_req = 1'b0;
        if (bus.mem_req && !out_active) begin
            chk("issue_addr", 32'(bus.mem_addr), 32'(exp_pc));
            out_active = 1'b1;
            out_drop   = 1'b0;
            out_addr   = bus.mem_addr;
            lat_left   = int'($urandom_range(lat_hi, lat_lo));
            new_req    = 1'b1;
        end else if (out_active) begin
            chk("addr_hold", 32'(bus.mem_addr), 32'(out_addr));
        end
        chk("count", 32'(bus.count), 32'(exp_q.size()));
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
        chk("num_fetched", 32'(bus.num_fetched), 32'(W'(nf_model)));
    endtask

    // Monitor: every decode handshake must deliver the oldest expected entry.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", bus.inst_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", 32'(bus.inst_pc), 32'(e[31:16]));
                    chk("head_data", 32'(bus.inst_data), 32'(e[15:0]));
                    nf_model++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b0;
        force_redir = 1'b0;
        force_pc    = '0;
        #2;

        // streaming with single-cycle ack
        do_reset();
        lat_lo = 0; lat_hi = 0; p_ready = 100; p_redir = 0; halt_v = 1'b0;
        step();
        chk("first_req", 32'(bus.mem_req), 32'd1);
        chk("first_addr", 32'(bus.mem_addr), 32'(RESET_PC));
        repeat (6) step();
        chk("fetched_5", 32'(bus.num_fetched), 32'd5);

        // fill with decode stalled, then a single pop re-enables fetch
        do_reset();
        p_ready = 0;
        repeat (10) step();
        chk("full_count", 32'(bus.count), 32'(DEPTH));
        chk("full_no_req", 32'(bus.mem_req), 32'd0);
        p_ready = 100;
        step();
        p_ready = 0;
        step();
        chk("refill_req", 32'(bus.mem_req), 32'd1);
        chk("refill_addr", 32'(bus.mem_addr), 32'h0004);

        // redirect with three entries queued and nothing outstanding
        do_reset();
        for (int i = 0; i < 20 && !(bus.count == 3 && !bus.mem_req); i++) begin
            halt_v = (bus.count >= 2);
            step();
        end
        chk("three_queued", 32'(bus.count), 32'd3);
        halt_v = 1'b0; force_redir = 1'b1; force_pc = 16'h0040;
        step();
        chk("redir_flush", 32'(bus.count), 32'd0);
        step();
        chk("redir_addr", 32'(bus.mem_addr), 32'h0040);
        p_ready = 100;
        for (int i = 0; i < 10 && !bus.inst_valid; i++) step();
        chk("redir_first_pc", 32'(bus.inst_pc), 32'h0040);

        // redirect while a slow request is outstanding
        do_reset();
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 100 && !(new_req && out_addr == 16'h0005); i++) step();
        chk("slow_req5", 32'(out_addr), 32'h0005);
        force_redir = 1'b1; force_pc = 16'h0100;
        step();
        for (int i = 0; i < 20 && !new_req; i++) step();
        chk("drop_then_addr", 32'(bus.mem_addr), 32'h0100);

        // redirect, ack and pop in the same cycle
        do_reset();
        lat_lo = 0; lat_hi = 0;
        repeat (4) step();
        chk("busy_valid", 32'(bus.inst_valid), 32'd1);
        nf = int'(bus.num_fetched);
        force_redir = 1'b1; force_pc = 16'h0200;
        step();
        chk("same_cycle_empty", 32'(bus.count), 32'd0);
        chk("same_cycle_nf", 32'(bus.num_fetched), 32'(nf));
        step();
        chk("same_cycle_addr", 32'(bus.mem_addr), 32'h0200);

        // halt mid-request, drain, resume, then reset mid-request
        do_reset();
        lat_lo = 2; lat_hi = 2; p_ready = 0;
        step();
        step();
        halt_v = 1'b1;
        repeat (6) step();
        chk("halt_enq", 32'(bus.count), 32'd1);
        chk("halt_no_req", 32'(bus.mem_req), 32'd0);
        p_ready = 100;
        repeat (2) step();
        chk("halt_drained", 32'(bus.count), 32'd0);
        halt_v = 1'b0;
        step();
        chk("resume_addr", 32'(bus.mem_addr), 32'h0001);
        step();
        do_reset();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) begin
                lat_lo  = 0;
                lat_hi  = int'($urandom_range(3, 0));
                p_ready = int'($urandom_range(100, 0));
                p_redir = int'($urandom_range(12, 0));
            end
            if ($urandom_range(19, 0) == 0) halt_v = !halt_v;
            if (i % 700 == 699) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
